uart_alu_ctrl: RTL and testbench

Command sequencer between the UART receiver and the ALU. It collects a 3-byte command frame from the received byte stream: a header carrying the opcode, then operand A, then operand B. It drives the ALU operands and opcode, waits a fixed settle time, then latches the ALU result and flags and strobes them to downstream logic (display/LEDs). It also recovers from framing errors, inter-byte timeouts and bytes that arrive while a command is executing.

---
 rtl/uart_alu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_ctrl
//
// Command sequencer between a UART receiver and an ALU. It collects a 3-byte
// frame (header with opcode, operand A, operand B), drives the ALU inputs,
// waits a fixed settle time, and then latches the ALU result and flags for
// downstream logic. It recovers from bad headers, inter-byte timeouts and
// bytes that arrive while a command is executing.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte
//   alu_result   combinational ALU result
//   alu_flags    combinational ALU flags {N,Z,C,V}
//   alu_a/alu_b  registered operands to the ALU
//   alu_op       registered opcode to the ALU
//   result/flags latched ALU outputs, held until the next result_valid
//   result_valid one-cycle strobe when result/flags update
//   busy         high whenever the sequencer is not idle
//   err_frame    one-cycle pulse: header byte with wrong upper nibble
//   err_timeout  one-cycle pulse: partial frame abandoned
//   err_overrun  one-cycle pulse: byte dropped while executing
// -----------------------------------------------------------------------------
module uart_alu_ctrl #(
    parameter int         DATA_W         = 8,
    parameter int         OP_W           = 4,
    parameter logic [3:0] HEADER_NIB     = 4'hA,
    parameter int         TIMEOUT_CYCLES = 13020,
    parameter int         SETTLE_CYCLES  = 2,
    parameter int         FLAG_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags,
    output logic              result_valid,
    output logic              busy,
    output logic              err_frame,
    output logic              err_timeout,
    output logic              err_overrun
);

    // Counter widths only need to hold the terminal value (count - 1).
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SET_W = (SETTLE_CYCLES  > 2) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GET_A, GET_B, EXEC} state_t;

    state_t              state_reg,   state_next;
    logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic [SET_W-1:0]    set_cnt_reg, set_cnt_next;
    logic [DATA_W-1:0]   alu_a_reg,   alu_a_next;
    logic [DATA_W-1:0]   alu_b_reg,   alu_b_next;
    logic [OP_W-1:0]     alu_op_reg,  alu_op_next;
    logic [DATA_W-1:0]   result_reg,  result_next;
    logic [FLAG_W-1:0]   flags_reg,   flags_next;
    logic                rvalid_reg,  rvalid_next;
    logic                eframe_reg,  eframe_next;
    logic                etmo_reg,    etmo_next;
    logic                eovr_reg,    eovr_next;

    logic header_ok;
    assign header_ok = (rx_data[DATA_W-1 -: 4] == HEADER_NIB);

    always_comb begin
        state_next   = state_reg;
        tmo_cnt_next = tmo_cnt_reg;
        set_cnt_next = set_cnt_reg;
        alu_a_next   = alu_a_reg;
        alu_b_next   = alu_b_reg;
        alu_op_next  = alu_op_reg;
        result_next  = result_reg;
        flags_next   = flags_reg;
        rvalid_next  = 1'b0;
        eframe_next  = 1'b0;
        etmo_next    = 1'b0;
        eovr_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                tmo_cnt_next = '0;
                if (rx_valid) begin
                    if (header_ok) begin
                        alu_op_next = rx_data[OP_W-1:0];
                        state_next  = GET_A;
                    end else begin
                        eframe_next = 1'b1;
                    end
                end
            end
            GET_A, GET_B: begin
                // An arriving byte always beats the terminal count.
                if (rx_valid) begin
                    tmo_cnt_next = '0;
                    if (state_reg == GET_A) begin
                        alu_a_next = rx_data;
                        state_next = GET_B;
                    end else begin
                        alu_b_next   = rx_data;
                        set_cnt_next = '0;
                        state_next   = EXEC;
                    end
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    tmo_cnt_next = '0;
                    etmo_next    = 1'b1;
                    state_next   = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            EXEC: begin
                // Any byte seen here is dropped, including on the completing edge.
                eovr_next = rx_valid;
                if (set_cnt_reg == SET_LAST) begin
                    result_next  = alu_result;
                    flags_next   = alu_flags;
                    rvalid_next  = 1'b1;
                    set_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    set_cnt_next = set_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tmo_cnt_reg <= '0;
            set_cnt_reg <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_op_reg  <= '0;
            result_reg  <= '0;
            flags_reg   <= '0;
            rvalid_reg  <= 1'b0;
            eframe_reg  <= 1'b0;
            etmo_reg    <= 1'b0;
            eovr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmo_cnt_reg <= tmo_cnt_next;
            set_cnt_reg <= set_cnt_next;
            alu_a_reg   <= alu_a_next;
            alu_b_reg   <= alu_b_next;
            alu_op_reg  <= alu_op_next;
            result_reg  <= result_next;
            flags_reg   <= flags_next;
            rvalid_reg  <= rvalid_next;
            eframe_reg  <= eframe_next;
            etmo_reg    <= etmo_next;
            eovr_reg    <= eovr_next;
        end
    end

    assign alu_a        = alu_a_reg;
    assign alu_b        = alu_b_reg;
    assign alu_op       = alu_op_reg;
    assign result       = result_reg;
    assign flags        = flags_reg;
    assign result_valid = rvalid_reg;
    assign busy         = (state_reg != IDLE);
    assign err_frame    = eframe_reg;
    assign err_timeout  = etmo_reg;
    assign err_overrun  = eovr_reg;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_ctrl
//
// Directed-vector bench for uart_alu_ctrl. Stimulus pushes the expected
// result/error events (with the cycle they must appear in) into per-kind
// queues; a monitor on the falling edge pops and compares whenever the DUT
// raises result_valid or an error pulse. A small behavioural ALU closes the
// loop on alu_a/alu_b/alu_op.
// -----------------------------------------------------------------------------
module tb_uart_alu_ctrl;

    localparam int T = 100;  // shortened timeout for simulation
    localparam int S = 2;

    localparam int K_NONE = 0;
    localparam int K_FRM  = 1;
    localparam int K_OVR  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [7:0] alu_a, alu_b, result;
    logic [3:0] alu_op, flags;
    logic       result_valid, busy, err_frame, err_timeout, err_overrun;

    uart_alu_ctrl #(
        .DATA_W(8), .OP_W(4), .HEADER_NIB(4'hA),
        .TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S), .FLAG_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .result(result), .flags(flags), .result_valid(result_valid),
        .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: op 1 subtract (C = borrow), op 2 xor, others add.
    logic [8:0] s9;
    always_comb begin
        s9 = 9'd0;
        case (alu_op)
            4'd1:    s9 = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2:    s9 = {1'b0, alu_a ^ alu_b};
            default: s9 = {1'b0, alu_a} + {1'b0, alu_b};
        endcase
        alu_result   = s9[7:0];
        alu_flags[3] = s9[7];
        alu_flags[2] = (s9[7:0] == 8'd0);
        alu_flags[1] = s9[8];
        if (alu_op == 4'd1)
            alu_flags[0] = (alu_a[7] != alu_b[7]) && (s9[7] != alu_a[7]);
        else if (alu_op == 4'd2)
            alu_flags[0] = 1'b0;
        else
            alu_flags[0] = (alu_a[7] == alu_b[7]) && (s9[7] != alu_a[7]);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int         cyc;
        logic [7:0] res;
        logic [3:0] flg;
    } res_t;

    res_t res_q[$];
    int   frm_q[$];
    int   tmo_q[$];
    int   ovr_q[$];

    // Scoreboard monitor.
    res_t mon_e;
    int   mon_c;
    always @(negedge clk) begin
        if (rst_n) begin
            if (result_valid) begin
                if (res_q.size() == 0) check("result_valid_unexpected", 1, 0);
                else begin
                    mon_e = res_q.pop_front();
                    check("result_valid_cycle", cyc, mon_e.cyc);
                    check("result", int'(result), int'(mon_e.res));
                    check("flags", int'(flags), int'(mon_e.flg));
                    $display("result %02h flags %01h at cycle %0d", result, flags, cyc);
                end
            end
            if (err_frame) begin
                if (frm_q.size() == 0) check("err_frame_unexpected", 1, 0);
                else begin
                    mon_c = frm_q.pop_front();
                    check("err_frame_cycle", cyc, mon_c);
                    $display("err_frame at cycle %0d", cyc);
                end
            end
            if (err_timeout) begin
                if (tmo_q.size() == 0) check("err_timeout_unexpected", 1, 0);
                else begin
                    mon_c = tmo_q.pop_front();
                    check("err_timeout_cycle", cyc, mon_c);
                    $display("err_timeout at cycle %0d", cyc);
                end
            end
            if (err_overrun) begin
                if (ovr_q.size() == 0) check("err_overrun_unexpected", 1, 0);
                else begin
                    mon_c = ovr_q.pop_front();
                    check("err_overrun_cycle", cyc, mon_c);
                    $display("err_overrun at cycle %0d", cyc);
                end
            end
        end
    end

    // Called at a falling edge; the byte is sampled on the next rising edge (k).
    task automatic drive(input logic [7:0] b, input int kind, output int k);
        k = cyc + 1;
        if (kind == K_FRM) frm_q.push_back(k);
        if (kind == K_OVR) ovr_q.push_back(k);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic [3:0] f, output int k);
        int kk;
        res_t e;
        drive(h, K_NONE, kk);
        drive(a, K_NONE, kk);
        drive(b, K_NONE, kk);
        k     = kk;
        e.cyc = kk + S;
        e.res = r;
        e.flg = f;
        res_q.push_back(e);
        $display("frame %02h %02h %02h -> expect %02h/%01h", h, a, b, r, f);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"}, int'(alu_a), 0);
        check({tag, "_alu_b"}, int'(alu_b), 0);
        check({tag, "_alu_op"}, int'(alu_op), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_flags"}, int'(flags), 0);
        check({tag, "_strobes"}, int'({result_valid, busy, err_frame, err_timeout, err_overrun}), 0);
    endtask

    initial begin
        int k;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check_all_zero("reset");
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Basic add frame.
        frame(8'hA3, 8'h05, 8'h03, 8'h08, 4'h0, k);
        check("t1_alu_op", int'(alu_op), 3);
        check("t1_alu_a", int'(alu_a), 8'h05);
        check("t1_alu_b", int'(alu_b), 8'h03);
        check("t1_busy_exec", int'(busy), 1);
        idle(S + 2);
        check("t1_busy_after", int'(busy), 0);

        // Bad header, then a subtract frame.
        drive(8'h5A, K_FRM, k);
        check("t2_busy", int'(busy), 0);
        check("t2_alu_op_kept", int'(alu_op), 3);
        frame(8'hA1, 8'h10, 8'h01, 8'h0F, 4'h0, k);
        idle(S + 2);

        // Timeout after operand A; B3 afterwards is evaluated as a header
        // and rejected for its upper nibble.
        drive(8'hA2, K_NONE, k);
        drive(8'h7F, K_NONE, k);
        tmo_q.push_back(k + T);
        check("t3_busy", int'(busy), 1);
        idle(T + 2);
        check("t3_busy_after", int'(busy), 0);
        check("t3_alu_op_kept", int'(alu_op), 2);
        check("t3_alu_a_kept", int'(alu_a), 8'h7F);
        drive(8'hB3, K_FRM, k);
        check("t3_alu_op_after_b3", int'(alu_op), 2);
        idle(2);

        // Operand B arrives exactly on the terminal-count cycle.
        drive(8'hA3, K_NONE, k);
        drive(8'h40, K_NONE, k);
        idle(T - 1);
        drive(8'h50, K_NONE, k);
        begin
            res_t e;
            e.cyc = k + S; e.res = 8'h90; e.flg = 4'h9;
            res_q.push_back(e);
        end
        check("t4_alu_b", int'(alu_b), 8'h50);
        check("t4_busy", int'(busy), 1);
        idle(S + 2);

        // Overrun: bytes during EXEC and on its completing edge are dropped.
        frame(8'hA0, 8'hFF, 8'h01, 8'h00, 4'h6, k);
        drive(8'hEE, K_OVR, k);
        drive(8'hA5, K_OVR, k);
        idle(2);
        check("t5_busy", int'(busy), 0);
        check("t5_alu_op", int'(alu_op), 0);
        check("t5_alu_a", int'(alu_a), 8'hFF);
        check("t5_alu_b", int'(alu_b), 8'h01);

        // Asynchronous reset while executing.
        drive(8'hA3, K_NONE, k);
        drive(8'h01, K_NONE, k);
        drive(8'h02, K_NONE, k);
        check("t6_busy_exec", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("t6_result_kept_zero", int'(result), 0);
        frame(8'hA1, 8'h01, 8'h02, 8'hFF, 4'hA, k);
        idle(S + 2);

        idle(5);
        check("pending_results", res_q.size(), 0);
        check("pending_frame_errs", frm_q.size(), 0);
        check("pending_timeouts", tmo_q.size(), 0);
        check("pending_overruns", ovr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
